// File: rtl/bp_resolve_pkg.sv
// bp_resolve_pkg: update codes, entry layout and small helpers shared by the
// branch predictor, the resolution tracker and the EX stage.
package bp_resolve_pkg;

    localparam logic [1:0] BT_NONE      = 2'b00;
    localparam logic [1:0] BT_NOT_TAKEN = 2'b01;
    localparam logic [1:0] BT_TAKEN     = 2'b10;

    localparam int PC_W  = 32;
    localparam int TGT_W = 32;

    // One in-flight prediction as recorded at fetch.
    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic             taken;
        logic [TGT_W-1:0] target;
    } bp_entry_t;

    // Counter-update code for a resolved control-transfer instruction.
    function automatic logic [1:0] bt_code(input logic cond, input logic taken);
        logic [1:0] code;
        case ({cond, taken})
            2'b11:   code = BT_TAKEN;
            2'b10:   code = BT_NOT_TAKEN;
            default: code = BT_NONE;
        endcase
        return code;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/bp_resolve_if.sv
// bp_resolve_if: prediction, resolution and feedback signals of bp_resolve.
// Optional BP_STATS_EN adds the two statistics counters.
interface bp_resolve_if;

    logic        pred_valid_i;
    logic        pred_taken_i;
    logic [31:0] pred_pc_i;
    logic [31:0] pred_target_i;
    logic        ex_valid_i;
    logic        ex_cond_i;
    logic        ex_taken_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_target_i;
    logic        flush_i;
    logic        full_o;
    logic        redirect_o;
    logic [31:0] redirect_addr_o;
    logic [1:0]  branch_taken_o;
    logic [31:0] ex_inst_addr_o;
    logic        err_o;
`ifdef BP_STATS_EN
    logic [31:0] stat_total_o;
    logic [31:0] stat_miss_o;
`endif

    modport slave (
`ifdef BP_STATS_EN
        output stat_total_o,
        output stat_miss_o,
`endif
        input  pred_valid_i,
        input  pred_taken_i,
        input  pred_pc_i,
        input  pred_target_i,
        input  ex_valid_i,
        input  ex_cond_i,
        input  ex_taken_i,
        input  ex_pc_i,
        input  ex_target_i,
        input  flush_i,
        output full_o,
        output redirect_o,
        output redirect_addr_o,
        output branch_taken_o,
        output ex_inst_addr_o,
        output err_o
    );

    modport master (
`ifdef BP_STATS_EN
        input  stat_total_o,
        input  stat_miss_o,
`endif
        output pred_valid_i,
        output pred_taken_i,
        output pred_pc_i,
        output pred_target_i,
        output ex_valid_i,
        output ex_cond_i,
        output ex_taken_i,
        output ex_pc_i,
        output ex_target_i,
        output flush_i,
        input  full_o,
        input  redirect_o,
        input  redirect_addr_o,
        input  branch_taken_o,
        input  ex_inst_addr_o,
        input  err_o
    );

endinterface

// File: rtl/bp_resolve_fifo.sv
// bp_resolve_fifo: the bp_fifo pointer FIFO holding in-flight predictions.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module bp_resolve_fifo
    import bp_resolve_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  logic      i_pop,
    input  logic      i_clear,
    input  bp_entry_t i_wdata,
    output bp_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int AW = $clog2(DEPTH);

    bp_entry_t      r_mem [DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic           w_do_push;
    logic           w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A pop while full frees the slot the same-cycle push lands in.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update: clear wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else if (i_clear) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage written at the tail slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push && !i_clear) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/bp_resolve.sv
// bp_resolve: tracks predictions from fetch, compares them with the EX
// outcome, raises a combinational redirect on mispredict and returns a
// registered counter update to the predictor.
// Optional feature macro: BP_STATS_EN (conditional resolution/miss counters).
module bp_resolve
    import bp_resolve_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    bp_resolve_if.slave   bus
);

    bp_entry_t   w_head;
    bp_entry_t   w_wdata;
    logic        w_full;
    logic        w_empty;
    logic        w_head_taken;
    logic [31:0] w_head_target;
    logic [31:0] w_head_pc;
    logic        w_mispredict;
    logic        w_redirect;
    logic [31:0] w_redirect_addr;
    logic        w_resolve;
    logic        w_push;
    logic        w_clear;
    logic        w_err_push;
    logic        w_err_ex;
    logic [1:0]  r_bt;
    logic [31:0] r_ex_addr;
    logic        r_err;

    assign w_wdata.pc     = bus.pred_pc_i;
    assign w_wdata.taken  = bus.pred_taken_i;
    assign w_wdata.target = bus.pred_target_i;

    // A flushed resolution neither pops nor produces an update.
    assign w_resolve = bus.ex_valid_i & ~bus.flush_i;
    // Everything in flight is wrong-path after a redirect, so drop it too.
    assign w_clear   = bus.flush_i | w_redirect;
    assign w_push    = bus.pred_valid_i & ~w_clear;

    bp_resolve_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_resolve),
        .i_clear (w_clear),
        .i_wdata (w_wdata),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Head view; an empty queue behaves as a not-taken prediction.
    always_comb begin
        w_head_taken  = 1'b0;
        w_head_target = 32'd0;
        w_head_pc     = 32'd0;
        if (!w_empty) begin
            w_head_taken  = w_head.taken;
            w_head_target = w_head.target;
            w_head_pc     = w_head.pc;
        end else begin
            w_head_taken  = 1'b0;
            w_head_target = 32'd0;
            w_head_pc     = 32'd0;
        end
    end

    // Direction mismatch, or taken to a different target than predicted.
    always_comb begin
        w_mispredict = 1'b0;
        if (w_head_taken != bus.ex_taken_i) begin
            w_mispredict = 1'b1;
        end else if (bus.ex_taken_i && (w_head_target != bus.ex_target_i)) begin
            w_mispredict = 1'b1;
        end else begin
            w_mispredict = 1'b0;
        end
    end

    assign w_redirect = w_resolve & w_mispredict & ~rst;

    // Correct next PC, forced to zero when no redirect is signalled.
    always_comb begin
        w_redirect_addr = 32'd0;
        if (!w_redirect) begin
            w_redirect_addr = 32'd0;
        end else if (bus.ex_taken_i) begin
            w_redirect_addr = bus.ex_target_i;
        end else begin
            w_redirect_addr = bus.ex_pc_i + 32'd4;
        end
    end

    // Protocol errors: overflowing push, resolve on empty, or PC mismatch.
    assign w_err_push = ~bus.flush_i & bus.pred_valid_i & w_full & ~bus.ex_valid_i;
    assign w_err_ex   = w_resolve & (w_empty | (w_head_pc != bus.ex_pc_i));

    // Counter update and its PC, valid only in the cycle after a resolution.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bt      <= BT_NONE;
            r_ex_addr <= 32'd0;
        end else if (w_resolve) begin
            r_bt      <= bt_code(bus.ex_cond_i, bus.ex_taken_i);
            r_ex_addr <= bus.ex_pc_i;
        end else begin
            r_bt      <= BT_NONE;
            r_ex_addr <= 32'd0;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_push || w_err_ex) begin
            r_err <= 1'b1;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] r_stat_total;
    logic [31:0] r_stat_miss;

    // Saturating counts of unflushed conditional resolutions and misses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_total <= 32'd0;
            r_stat_miss  <= 32'd0;
        end else if (w_resolve && bus.ex_cond_i) begin
            r_stat_total <= sat_inc(r_stat_total);
            if (w_mispredict) begin
                r_stat_miss <= sat_inc(r_stat_miss);
            end
        end
    end

    assign bus.stat_total_o = r_stat_total;
    assign bus.stat_miss_o  = r_stat_miss;
`endif

    assign bus.full_o          = w_full;
    assign bus.redirect_o      = w_redirect;
    assign bus.redirect_addr_o = w_redirect_addr;
    assign bus.branch_taken_o  = r_bt;
    assign bus.ex_inst_addr_o  = r_ex_addr;
    assign bus.err_o           = r_err;

endmodule

// File: tb/tb_bp_resolve.sv
// tb_bp_resolve: directed table, corner sequences and randomized traffic
// compared against a queue-based reference model of bp_resolve.
module tb_bp_resolve;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
    } ent_t;

    typedef struct packed {
        logic        pv;
        logic        pt;
        logic [31:0] ppc;
        logic [31:0] ptg;
        logic        ev;
        logic        ec;
        logic        et;
        logic [31:0] epc;
        logic [31:0] etg;
        logic        fl;
        logic        e_red;
        logic [31:0] e_raddr;
        logic [1:0]  e_bt;
        logic [31:0] e_addr;
        logic        e_err;
    } vec_t;

    logic clk;
    logic rst;
    bp_resolve_if bus ();

    bp_resolve #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    ent_t        mq[$];
    logic        m_err;
    logic [1:0]  m_bt;
    logic [31:0] m_addr;
    logic        s_full;
    logic        s_red;
    logic [31:0] s_raddr;
    vec_t        tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic pv, input logic pt, input logic [31:0] ppc,
                                input logic [31:0] ptg, input logic ev, input logic ec,
                                input logic et, input logic [31:0] epc, input logic [31:0] etg,
                                input logic fl, input logic e_red, input logic [31:0] e_raddr,
                                input logic [1:0] e_bt, input logic [31:0] e_addr,
                                input logic e_err);
        vec_t v;
        v.pv = pv; v.pt = pt; v.ppc = ppc; v.ptg = ptg;
        v.ev = ev; v.ec = ec; v.et = et; v.epc = epc; v.etg = etg; v.fl = fl;
        v.e_red = e_red; v.e_raddr = e_raddr; v.e_bt = e_bt; v.e_addr = e_addr;
        v.e_err = e_err;
        return v;
    endfunction

    // Apply one cycle of inputs; check combinational outputs before the edge
    // and registered outputs after it, advancing the reference model.
    task automatic step(input logic pv, input logic pt, input logic [31:0] ppc,
                        input logic [31:0] ptg, input logic ev, input logic ec,
                        input logic et, input logic [31:0] epc, input logic [31:0] etg,
                        input logic fl);
        logic        emp;
        logic        ful;
        logic        h_t;
        logic [31:0] h_tg;
        logic        misp;
        logic        red;
        logic [31:0] raddr;
        ent_t        e;
        bus.pred_valid_i  = pv;
        bus.pred_taken_i  = pt;
        bus.pred_pc_i     = ppc;
        bus.pred_target_i = ptg;
        bus.ex_valid_i    = ev;
        bus.ex_cond_i     = ec;
        bus.ex_taken_i    = et;
        bus.ex_pc_i       = epc;
        bus.ex_target_i   = etg;
        bus.flush_i       = fl;
        #1;
        emp  = (mq.size() == 0);
        ful  = (mq.size() == DEPTH);
        h_t  = 1'b0;
        h_tg = 32'd0;
        if (!emp) begin
            h_t  = mq[0].taken;
            h_tg = mq[0].tgt;
        end
        misp  = (h_t != et) || (et && (h_tg != etg));
        red   = ev && misp && !fl;
        raddr = !red ? 32'd0 : (et ? etg : epc + 32'd4);
        s_full  = bus.full_o;
        s_red   = bus.redirect_o;
        s_raddr = bus.redirect_addr_o;
        chk("full_o", {31'd0, s_full}, {31'd0, ful});
        chk("redirect_o", {31'd0, s_red}, {31'd0, red});
        chk("redirect_addr_o", s_raddr, raddr);
        if (!fl) begin
            if (pv && ful && !ev) m_err = 1'b1;
            if (ev) begin
                if (emp) m_err = 1'b1;
                else if (mq[0].pc != epc) m_err = 1'b1;
            end
        end
        if (ev && !fl) begin
            m_bt   = !ec ? 2'b00 : (et ? 2'b10 : 2'b01);
            m_addr = epc;
        end else begin
            m_bt   = 2'b00;
            m_addr = 32'd0;
        end
        if (fl || red) begin
            mq.delete();
        end else begin
            if (ev && !emp) void'(mq.pop_front());
            if (pv && (!ful || ev)) begin
                e.pc = ppc; e.taken = pt; e.tgt = ptg;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk("branch_taken_o", {30'd0, bus.branch_taken_o}, {30'd0, m_bt});
        chk("ex_inst_addr_o", bus.ex_inst_addr_o, m_addr);
        chk("err_o", {31'd0, bus.err_o}, {31'd0, m_err});
    endtask

    task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        step(1'b1, t, pc, tg, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        bus.pred_valid_i = 1'b0; bus.pred_taken_i = 1'b0;
        bus.pred_pc_i = 32'd0; bus.pred_target_i = 32'd0;
        bus.ex_valid_i = 1'b0; bus.ex_cond_i = 1'b0; bus.ex_taken_i = 1'b0;
        bus.ex_pc_i = 32'd0; bus.ex_target_i = 32'd0; bus.flush_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst full_o", {31'd0, bus.full_o}, 32'd0);
        chk("rst redirect_o", {31'd0, bus.redirect_o}, 32'd0);
        chk("rst redirect_addr_o", bus.redirect_addr_o, 32'd0);
        chk("rst branch_taken_o", {30'd0, bus.branch_taken_o}, 32'd0);
        chk("rst ex_inst_addr_o", bus.ex_inst_addr_o, 32'd0);
        chk("rst err_o", {31'd0, bus.err_o}, 32'd0);
        mq.delete();
        m_err = 1'b0; m_bt = 2'b00; m_addr = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        do_reset();

        // Directed table: pv pt ppc ptg | ev ec et epc etg | fl | red raddr bt addr err
        tbl[0] = mk(1,1,32'h100,32'h140, 0,0,0,32'h0,32'h0,   0, 0,32'h0,  2'b00,32'h0,  0);
        tbl[1] = mk(0,0,32'h0,32'h0,     1,1,1,32'h100,32'h140,0, 0,32'h0,  2'b10,32'h100,0);
        tbl[2] = mk(0,0,32'h0,32'h0,     0,0,0,32'h0,32'h0,   0, 0,32'h0,  2'b00,32'h0,  0);
        tbl[3] = mk(1,0,32'h200,32'h0,   0,0,0,32'h0,32'h0,   0, 0,32'h0,  2'b00,32'h0,  0);
        tbl[4] = mk(0,0,32'h0,32'h0,     1,1,1,32'h200,32'h260,0, 1,32'h260,2'b10,32'h200,0);
        tbl[5] = mk(0,0,32'h0,32'h0,     0,0,0,32'h0,32'h0,   0, 0,32'h0,  2'b00,32'h0,  0);
        tbl[6] = mk(1,1,32'h300,32'h340, 0,0,0,32'h0,32'h0,   0, 0,32'h0,  2'b00,32'h0,  0);
        tbl[7] = mk(0,0,32'h0,32'h0,     1,1,0,32'h300,32'h0, 0, 1,32'h304,2'b01,32'h300,0);
        tbl[8] = mk(1,1,32'h400,32'h480, 0,0,0,32'h0,32'h0,   0, 0,32'h0,  2'b00,32'h0,  0);
        tbl[9] = mk(0,0,32'h0,32'h0,     1,0,1,32'h400,32'h480,0, 0,32'h0,  2'b00,32'h400,0);
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].pv, tbl[i].pt, tbl[i].ppc, tbl[i].ptg, tbl[i].ev, tbl[i].ec,
                 tbl[i].et, tbl[i].epc, tbl[i].etg, tbl[i].fl);
            chk($sformatf("vec%0d redirect", i), {31'd0, s_red}, {31'd0, tbl[i].e_red});
            chk($sformatf("vec%0d redirect_addr", i), s_raddr, tbl[i].e_raddr);
            chk($sformatf("vec%0d branch_taken", i), {30'd0, bus.branch_taken_o}, {30'd0, tbl[i].e_bt});
            chk($sformatf("vec%0d ex_inst_addr", i), bus.ex_inst_addr_o, tbl[i].e_addr);
            chk($sformatf("vec%0d err", i), {31'd0, bus.err_o}, {31'd0, tbl[i].e_err});
        end

        // Fill, overflow, then push+pop while full across the pointer wrap.
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(32'hA00 + 32'(4 * i), 1'b1, 32'hA40 + 32'(4 * i));
        push(32'hA10, 1'b1, 32'hA50);
        chk("fill full_o", {31'd0, s_full}, 32'd1);
        chk("overflow err_o", {31'd0, bus.err_o}, 32'd1);
        step(1'b1, 1'b1, 32'hA14, 32'hA54, 1'b1, 1'b1, 1'b1, 32'hA00, 32'hA40, 1'b0);
        chk("full push+pop redirect", {31'd0, s_red}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 32'hA04, 32'hA44, 1'b0);
        chk("still full after push+pop", {31'd0, s_full}, 32'd1);
        chk("wrap order A04", {31'd0, s_red}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 32'hA08, 32'hA48, 1'b0);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 32'hA0C, 32'hA4C, 1'b0);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 32'hA14, 32'hA54, 1'b0);
        chk("wrap order A14", {31'd0, s_red}, 32'd0);
        chk("wrap A14 update pc", bus.ex_inst_addr_o, 32'hA14);

        // Flush with a same-cycle resolution and push.
        do_reset();
        push(32'hB00, 1'b0, 32'd0);
        push(32'hB04, 1'b0, 32'd0);
        push(32'hB08, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'hB00, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'hB0C, 32'd0, 1'b1, 1'b1, 1'b1, 32'hB04, 32'hBEE, 1'b1);
        chk("flush redirect_o", {31'd0, s_red}, 32'd0);
        chk("flush redirect_addr_o", s_raddr, 32'd0);
        chk("flush branch_taken_o", {30'd0, bus.branch_taken_o}, 32'd0);
        chk("flush ex_inst_addr_o", bus.ex_inst_addr_o, 32'd0);
        for (int i = 0; i < DEPTH; i++) push(32'hC00 + 32'(4 * i), 1'b0, 32'd0);
        chk("post-flush empty (4th push not full)", {31'd0, s_full}, 32'd0);
        idle();
        chk("post-flush refill full", {31'd0, s_full}, 32'd1);

        // PC mismatch sets a sticky error; async reset mid-stream clears it.
        do_reset();
        push(32'h504, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h500, 32'd0, 1'b0);
        chk("pc mismatch err_o", {31'd0, bus.err_o}, 32'd1);
        chk("pc mismatch redirect_o", {31'd0, s_red}, 32'd0);
        for (int i = 0; i < 3; i++) idle();
        chk("err_o sticky", {31'd0, bus.err_o}, 32'd1);
        push(32'h600, 1'b1, 32'h640);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h600, 32'h640, 1'b0);
        chk("pending update before rst", {30'd0, bus.branch_taken_o}, 32'd2);
        do_reset();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 2000; n++) begin
            logic        pv, pt, ev, ec, et, fl;
            logic [31:0] ppc, ptg, epc, etg;
            if (n % 250 == 249) do_reset();
            pv  = ($urandom_range(0, 9) < 6);
            pt  = 1'($urandom_range(0, 1));
            ppc = 32'h1000 + 32'(4 * $urandom_range(0, 15));
            ptg = 32'h2000 + 32'(4 * $urandom_range(0, 3));
            ev  = ($urandom_range(0, 9) < 4);
            ec  = 1'($urandom_range(0, 1));
            et  = 1'($urandom_range(0, 1));
            epc = 32'h1000 + 32'(4 * $urandom_range(0, 15));
            etg = 32'h2000 + 32'(4 * $urandom_range(0, 3));
            if (mq.size() > 0 && $urandom_range(0, 9) < 8) epc = mq[0].pc;
            if (mq.size() > 0 && $urandom_range(0, 9) < 7) begin
                etg = mq[0].tgt;
                et  = mq[0].taken;
            end
            if (n % 500 == 7) epc = 32'hFFFF_FFFC;
            fl  = ($urandom_range(0, 19) == 0);
            step(pv, pt, ppc, ptg, ev, ec, et, epc, etg, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
